// File: rtl/regfile_wr_arbiter.sv
// Write-port sequencer for the 16x16 register file: zero-fills after reset,
// then arbitrates ALU and load writebacks onto one registered write port.
module regfile_wr_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter bit          ZERO_R0      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [3:0]  a_reg,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        m_valid,
    input  logic [3:0]  m_reg,
    input  logic [15:0] m_data,
    output logic        m_ready,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    output logic        init_done
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  starve;
    logic        starve_hit;
    logic        xfer;
    logic        suppress;
    logic [3:0]  win_reg;
    logic [15:0] win_data;

    assign starve_hit = (starve >= LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && cnt == 4'd15) begin
            state_next = RUN;
        end
    end

    // Load path has priority unless the ALU has been denied too long.
    always_comb begin
        a_ready   = 1'b0;
        m_ready   = 1'b0;
        init_done = 1'b0;
        if (state == RUN) begin
            init_done = 1'b1;
            if (a_valid && (starve_hit || !m_valid)) begin
                a_ready = 1'b1;
            end else if (m_valid) begin
                m_ready = 1'b1;
            end
        end
    end

    assign xfer     = a_ready | m_ready;
    assign win_reg  = m_ready ? m_reg : a_reg;
    assign win_data = m_ready ? m_data : a_data;
    assign suppress = ZERO_R0 && (win_reg == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (state == INIT) begin
            cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= 4'd0;
        end else if (state != RUN || !a_valid || a_ready) begin
            starve <= 4'd0;
        end else if (starve != 4'd15) begin
            starve <= starve + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WriteReg <= 1'b0;
            DstReg   <= 4'd0;
            DstData  <= 16'd0;
        end else if (state == INIT) begin
            WriteReg <= 1'b1;
            DstReg   <= cnt;
            DstData  <= 16'd0;
        end else if (xfer && !suppress) begin
            WriteReg <= 1'b1;
            DstReg   <= win_reg;
            DstData  <= win_data;
        end else begin
            WriteReg <= 1'b0;
        end
    end

endmodule
